// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: RV32M multiply/divide sequencer next to the EX stage.
// Latency: NB_WORD+1 cycles from accept to o_valid. Divide-by-zero and signed overflow finish in 1 cycle.
// Backpressure: o_busy stalls EX while an operation is accepted or in progress. Only one operation runs at a time.
//
// Ports:
//   i_clock   - clock; all state changes on the rising edge
//   i_reset   - synchronous active-low reset
//   i_valid   - start request. Ignored unless idle; ignored if i_flush is high.
//   i_funct3  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   i_op1     - rs1 value (dividend / multiplicand)
//   i_op2     - rs2 value (divisor / multiplier)
//   i_flush   - abort any operation in flight and suppress its result pulse
//   o_busy    - stall request to hazard logic
//   o_valid   - one-cycle result pulse
//   o_result  - result during the pulse; holds the last result between pulses
module ex_muldiv_seq #(
  parameter int NB_WORD = 32,
  parameter int NB_CNT  = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [2:0]         i_funct3,
  input  logic [NB_WORD-1:0] i_op1,
  input  logic [NB_WORD-1:0] i_op2,
  input  logic               i_flush,
  output logic               o_busy,
  output logic               o_valid,
  output logic [NB_WORD-1:0] o_result
);

  localparam int NB_ACC = 2 * NB_WORD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // State. acc_q is shared by both algorithms.
  //   Multiply: {partial product high, multiplier being shifted out / product low}.
  //   Divide:   {partial remainder, dividend being shifted out / quotient}.
  // opd_q holds the multiplicand magnitude for multiply and the divisor magnitude for divide.
  state_t              state_q,   state_d;
  logic [NB_CNT-1:0]   cnt_q,     cnt_d;
  logic [2:0]          funct3_q,  funct3_d;
  logic [NB_WORD-1:0]  opd_q,     opd_d;
  logic [NB_ACC-1:0]   acc_q,     acc_d;
  logic                neg_q,     neg_d;      // negate product / quotient
  logic                neg_rem_q, neg_rem_d;  // remainder follows dividend sign
  logic [NB_WORD-1:0]  result_q,  result_d;

  // ---------------------------------------------------------------------------
  // Operand decode at accept time
  // ---------------------------------------------------------------------------
  logic               op1_signed, op2_signed;
  logic               s1, s2;
  logic [NB_WORD-1:0] mag1, mag2;
  logic               is_div_in;
  logic               div_zero;
  logic               div_ovf;
  logic               accept;

  always_comb begin
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    unique case (i_funct3)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      3'd2: op1_signed = 1'b1;
      default: ;
    endcase
  end

  assign s1        = op1_signed & i_op1[NB_WORD-1];
  assign s2        = op2_signed & i_op2[NB_WORD-1];
  assign mag1      = s1 ? -i_op1 : i_op1;
  assign mag2      = s2 ? -i_op2 : i_op2;
  assign is_div_in = i_funct3[2];
  assign div_zero  = is_div_in && (i_op2 == '0);
  // Only DIV/REM (funct3 4 or 6) can overflow: most-negative / -1.
  assign div_ovf   = is_div_in && !i_funct3[0]
                     && (i_op1 == {1'b1, {(NB_WORD-1){1'b0}}})
                     && (i_op2 == {NB_WORD{1'b1}});
  assign accept    = (state_q == ST_IDLE) && i_valid && !i_flush;

  // ---------------------------------------------------------------------------
  // One iteration of each datapath
  // ---------------------------------------------------------------------------
  // Shift-add multiply, LSB first.
  // The carry out of the high-half add becomes the new MSB after the right shift.
  logic [NB_WORD:0]  mul_sum;
  logic [NB_ACC-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[NB_ACC-1:NB_WORD]}
                    + (acc_q[0] ? {1'b0, opd_q} : {(NB_WORD+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[NB_WORD-1:1]};

  // Restoring divide, MSB first.
  // The trial subtraction is one bit wider than the word.
  // Bit NB_WORD of the difference is the borrow, so no-borrow means the divisor fits.
  logic [NB_WORD:0]  div_diff;
  logic              div_fits;
  logic [NB_ACC-1:0] div_next;

  assign div_diff = acc_q[NB_ACC-1:NB_WORD-1] - {1'b0, opd_q};
  assign div_fits = !div_diff[NB_WORD];
  assign div_next = div_fits ? {div_diff[NB_WORD-1:0], acc_q[NB_WORD-2:0], 1'b1}
                             : {acc_q[NB_ACC-2:0], 1'b0};

  // ---------------------------------------------------------------------------
  // Sign correction and result select (used in DONE)
  // ---------------------------------------------------------------------------
  logic [NB_ACC-1:0]  prod_fix;
  logic [NB_WORD-1:0] quot_fix;
  logic [NB_WORD-1:0] rem_fix;
  logic [NB_WORD-1:0] final_res;

  assign prod_fix = neg_q     ? -acc_q : acc_q;
  assign quot_fix = neg_q     ? -acc_q[NB_WORD-1:0] : acc_q[NB_WORD-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[NB_ACC-1:NB_WORD] : acc_q[NB_ACC-1:NB_WORD];

  always_comb begin
    final_res = '0;
    unique case (funct3_q)
      3'd0:             final_res = prod_fix[NB_WORD-1:0];
      3'd1, 3'd2, 3'd3: final_res = prod_fix[NB_ACC-1:NB_WORD];
      3'd4, 3'd5:       final_res = quot_fix;
      default:          final_res = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The result is shown combinationally during DONE, so that a flush in that
  // same cycle can still hide it.
  // result_q captures it at the end of DONE for the hold value.
  assign o_valid  = i_reset && (state_q == ST_DONE) && !i_flush;
  assign o_busy   = i_reset && ((state_q == ST_CALC) || accept);
  assign o_result = o_valid ? final_res : result_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    opd_d     = opd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          funct3_d = i_funct3;
          cnt_d    = '0;
          if (div_zero) begin
            // Quotient is all ones; the remainder is the raw dividend.
            acc_d     = {i_op1, {NB_WORD{1'b1}}};
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = ST_DONE;
          end else if (div_ovf) begin
            // Quotient wraps to the dividend; the remainder is zero.
            acc_d     = {{NB_WORD{1'b0}}, i_op1};
            neg_d     = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = ST_DONE;
          end else if (is_div_in) begin
            opd_d     = mag2;
            acc_d     = {{NB_WORD{1'b0}}, mag1};
            neg_d     = s1 ^ s2;
            neg_rem_d = s1;
            state_d   = ST_CALC;
          end else begin
            opd_d     = mag1;
            acc_d     = {{NB_WORD{1'b0}}, mag2};
            neg_d     = s1 ^ s2;
            neg_rem_d = 1'b0;
            state_d   = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = funct3_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == NB_CNT'(NB_WORD - 1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (o_valid) begin
          result_d = final_res;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      opd_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      opd_q     <= opd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: directed bench for the RV32M multiply/divide sequencer.
// Each step drives inputs 1ns after the rising edge and samples 2ns later.
// Cycle 0 of an operation is the cycle in which i_valid is presented.
module tb_ex_muldiv_seq;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic [2:0]  i_funct3;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        i_flush;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  int total = 0;
  int bad   = 0;

  ex_muldiv_seq #(.NB_WORD(32), .NB_CNT(6)) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .i_funct3 (i_funct3),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .i_flush  (i_flush),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait a bounded time for its result pulse.
  // If inject_at >= 0, a second (DIVU 100/7) request is pulsed at that cycle
  // while the first operation is still running.
  // Returns positioned in the cycle right after the pulse.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat,
                        input int inject_at);
    int lat;
    int busy_cnt;
    bit seen;
    lat = -1;
    busy_cnt = 0;
    seen = 1'b0;
    i_valid = 1'b1;
    i_funct3 = f3;
    i_op1 = a;
    i_op2 = b;
    for (int c = 0; c < 60 && !seen; c++) begin
      #2;
      if (c == 0) check({tag, "_nopulse_c0"}, {31'b0, o_valid}, 32'd0);
      if (o_valid) begin
        seen = 1'b1;
        lat = c;
        check({tag, "_result"}, o_result, exp);
        check({tag, "_busy_done"}, {31'b0, o_busy}, 32'd0);
      end else if (o_busy) begin
        busy_cnt++;
      end
      tick();
      i_valid = (c + 1 == inject_at);
      if (c + 1 == inject_at) begin
        i_funct3 = 3'd5;
        i_op1 = 32'd100;
        i_op2 = 32'd7;
      end
    end
    check({tag, "_seen"}, {31'b0, seen}, 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
  endtask

  initial begin
    int vcnt;
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_funct3 = 3'd0;
    i_op1 = '0;
    i_op2 = '0;
    i_flush = 1'b0;

    // Reset state
    tick();
    tick();
    i_reset = 1'b1;
    #2;
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    tick();

    // Multiplies. Each op starts the cycle after the previous pulse (back-to-back).
    run_op("mul_7_m3",  3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, -1);
    run_op("mulh_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, -1);
    run_op("mulhu_ff",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, -1);
    run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -1);
    // 0x12345678 * 0x9ABCDEF0 = 0x0B00EA4E_242D2080
    run_op("mulhu_big", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 33, -1);

    // Divides
    run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, -1);
    run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, -1);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33, -1);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33, -1);
    run_op("rem_7_m2",  3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33, -1);

    // Special divides resolve in one cycle
    run_op("divu_by0",  3'd5, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1, -1);
    run_op("remu_by0",  3'd7, 32'h0000_1234, 32'h0, 32'h0000_1234, 1, -1);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, -1);
    run_op("div_m7_by0", 3'd4, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 1, -1);
    run_op("rem_m7_by0", 3'd6, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 1, -1);

    // Flush during CALC at cycle 10. o_result must keep 0xFFFFFFF9.
    vcnt = 0;
    i_valid = 1'b1;
    i_funct3 = 3'd0;
    i_op1 = 32'h0001_2345;
    i_op2 = 32'h0000_0678;
    #2;
    check("flush_busy_c0", {31'b0, o_busy}, 32'd1);
    tick();
    i_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      #2;
      if (o_valid) vcnt++;
      tick();
    end
    i_flush = 1'b1;
    #2;
    check("flush_valid_c10", {31'b0, o_valid}, 32'd0);
    tick();
    i_flush = 1'b0;
    #2;
    check("flush_busy_c11", {31'b0, o_busy}, 32'd0);
    check("flush_valid_c11", {31'b0, o_valid}, 32'd0);
    check("flush_hold_c11", o_result, 32'hFFFF_FFF9);
    check("flush_no_pulse", vcnt, 0);
    tick();
    run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 33, -1);

    // Flush in DONE (divide by zero reaches DONE at cycle 1) suppresses the pulse
    i_valid = 1'b1;
    i_funct3 = 3'd5;
    i_op1 = 32'd5;
    i_op2 = 32'd0;
    tick();
    i_valid = 1'b0;
    i_flush = 1'b1;
    #2;
    check("dflush_valid", {31'b0, o_valid}, 32'd0);
    check("dflush_result", o_result, 32'd3);
    tick();
    i_flush = 1'b0;
    #2;
    check("dflush_valid_after", {31'b0, o_valid}, 32'd0);
    check("dflush_hold", o_result, 32'd3);
    check("dflush_busy", {31'b0, o_busy}, 32'd0);
    tick();

    // Reset at cycle 5 of a DIV
    i_valid = 1'b1;
    i_funct3 = 3'd4;
    i_op1 = 32'd100;
    i_op2 = 32'd7;
    #2;
    check("rstmid_busy_c0", {31'b0, o_busy}, 32'd1);
    tick();
    i_valid = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    #2;
    check("rstmid_busy", {31'b0, o_busy}, 32'd0);
    check("rstmid_valid", {31'b0, o_valid}, 32'd0);
    check("rstmid_result", o_result, 32'd0);
    vcnt = 0;
    for (int k = 0; k < 35; k++) begin
      tick();
      #2;
      if (o_valid) vcnt++;
    end
    check("rstmid_no_pulse", vcnt, 0);
    tick();

    // A request pulsed during CALC is ignored: one result, no second pulse
    run_op("mul_3_5_inj", 3'd0, 32'd3, 32'd5, 32'd15, 33, 5);
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (o_valid) vcnt++;
      tick();
    end
    check("inj_no_second", vcnt, 0);
    check("inj_hold", o_result, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations. It sits beside the execution unit in EX.
- Accepts one operation at a time from EX, iterates a shift-add multiplier or restoring divider one bit per cycle, and stalls the pipeline while busy.
- Delivers a single-cycle result pulse that EX muxes onto its result path.

Parameters:
NB_WORD, 32, operand/result width (bits)
NB_CNT, 6, iteration counter width; must satisfy 2**NB_CNT > NB_WORD

Ports:
i_clock  input  1  clock, all state updates on rising edge
i_reset  input  1  reset; synchronous, active-low
i_valid  input  1  start request from EX (M-extension instruction present)
i_funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_op1  input  NB_WORD  rs1 value, already forwarded
i_op2  input  NB_WORD  rs2 value, already forwarded
i_flush  input  1  abort current operation (branch/exception flush)
o_busy  output  1  stall request to hazard logic
o_valid  output  1  result-valid pulse, one cycle
o_result  output  NB_WORD  result; holds last value between pulses

Behaviour:
- Reset (i_reset low at clock edge): state IDLE, counter 0, o_busy 0, o_valid 0, o_result 0, internal accumulators 0. Reset overrides all other inputs, including mid-operation.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On i_valid=1 and i_flush=0, latch funct3 and operands. Compute operand magnitudes and result-sign flags per signedness: MUL/MULH/DIV/REM both signed; MULHSU op1 signed only; others unsigned. Clear counter.
  - Go to CALC, except for the special divide cases below, which go to DONE.
  - i_valid with i_flush in the same cycle: ignored, stay IDLE.
- CALC:
  - One iteration per cycle, counter increments.
  - Multiply: 2*NB_WORD-bit product, shift-add, LSB-first.
  - Divide: restoring divide, MSB-first, NB_WORD-bit quotient and remainder.
  - After NB_WORD iterations (counter == NB_WORD-1 at the edge), go to DONE.
- DONE:
  - Apply sign correction:
    - Multiply: negate the 2*NB_WORD-bit product if the signs differ.
    - DIV: negate the quotient if the operand signs differ.
    - REM: remainder takes the sign of the dividend.
  - Select the result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
  - Register it into o_result with o_valid=1 for exactly this cycle, then return to IDLE.
- o_busy = 1 in CALC, and in IDLE on the cycle i_valid=1 is accepted (combinational, so EX holds the instruction). o_busy = 0 in DONE, so the pipeline advances and captures o_result.
- Latency: i_valid accepted at cycle 0 -> o_valid at cycle NB_WORD+1.
- Special divide cases, resolved in IDLE and sent to DONE (o_valid at cycle 1):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> op1.
  - Signed overflow (op1 = 0x80000000, op2 = 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- i_valid while in CALC or DONE: ignored; no queueing.
- i_flush in CALC or DONE: next state IDLE, o_valid stays 0 (the flush suppresses the pulse in DONE), and o_result keeps its previous value.
- Back-to-back: a new i_valid in the cycle after DONE is accepted normally.
- All arithmetic is modulo 2**NB_WORD per result half; there are no exceptions or flags.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> o_valid at cycle 33, o_result 0xFFFFFFEB; o_busy high cycles 0..32.
- MULH vs MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> MULH 0x00000000, MULHU 0xFFFFFFFE; MULHSU same operands -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14, REMU -> 2.
- DIVU x / 0 with op1 = 0x1234 -> o_result 0xFFFFFFFF at cycle 1; REMU -> 0x00001234. DIV 0x80000000 / -1 -> 0x80000000 at cycle 1.
- Start MUL, assert i_flush at cycle 10 -> IDLE at cycle 11, no o_valid, o_result unchanged. New DIVU 9 / 3 accepted at cycle 12 -> 3 at cycle 45.
- Drive i_reset low at cycle 5 of a DIV -> o_busy/o_valid/o_result all 0 next cycle. An i_valid pulsed during CALC of another op is ignored and produces no second o_valid.
